// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one memory bus between instruction fetch (IF) and
//            load/store (LS), one outstanding transaction, LS priority.
//            Optional IF starvation guard enabled by ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [BUS_WIDTH-1:0]    if_addr,
    input  logic                    cancel_if,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [BUS_WIDTH-1:0]    ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wmask,
    output logic                    ls_gnt,
    output logic                    ls_rvalid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [BUS_WIDTH-1:0]    bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_wmask,
    input  logic                    bus_ready,
    input  logic                    bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_ISSUE_IF = 5'b00010,
        S_ISSUE_LS = 5'b00100,
        S_WAIT_IF  = 5'b01000,
        S_WAIT_LS  = 5'b10000
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t                  state_q, state_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [BUS_WIDTH-1:0]    bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH/8-1:0] bus_wmask_q, bus_wmask_d;
    logic                    drop_q, drop_d;
    logic                    if_eff;
    logic                    starve_hit;
    logic                    grant_ls;

    assign if_eff   = if_req && !cancel_if;
    // The starve guard can only flip priority when both sides are asking.
    assign grant_ls = ls_req && !(starve_hit && if_eff);

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;

    assign starve_hit = (starve_q == STARVE_LIM);

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || (state_q == S_IDLE && !if_eff)) begin
            starve_d = 3'd0;
        end else if (ls_gnt && if_eff && starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= 3'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_hit = (STARVE_LIM == 3'd0) && 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        drop_d      = drop_q;
        if_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        ls_gnt      = 1'b0;
        ls_rvalid   = 1'b0;
        ls_rdata    = '0;
        // Combinational outputs are held at zero while reset is asserted.
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (grant_ls) begin
                        ls_gnt      = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = ls_we;
                        bus_addr_d  = ls_addr;
                        bus_wdata_d = ls_wdata;
                        bus_wmask_d = ls_wmask;
                        state_d     = S_ISSUE_LS;
                    end else if (if_eff) begin
                        if_gnt      = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        bus_wmask_d = '0;
                        state_d     = S_ISSUE_IF;
                    end
                end
                S_ISSUE_IF: begin
                    if (cancel_if) drop_d = 1'b1;
                    if (bus_ready) begin
                        bus_req_d = 1'b0;
                        state_d   = S_WAIT_IF;
                    end
                end
                S_ISSUE_LS: begin
                    if (bus_ready) begin
                        bus_req_d = 1'b0;
                        state_d   = S_WAIT_LS;
                    end
                end
                S_WAIT_IF: begin
                    if (bus_rvalid) begin
                        if_rvalid = !drop_q && !cancel_if;
                        if_rdata  = bus_rdata;
                        drop_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else if (cancel_if) begin
                        drop_d = 1'b1;
                    end
                end
                S_WAIT_LS: begin
                    if (bus_rvalid) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = bus_rdata;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    bus_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            drop_q      <= drop_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, cancel_if, ls_req, ls_we, bus_ready, bus_rvalid;
    logic [31:0] if_addr, ls_addr, ls_wdata, bus_rdata;
    logic [3:0]  ls_wmask;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, bus_req, bus_we;
    logic [31:0] if_rdata, ls_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wmask;
    int          errors;
    int          checks;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.BUS_WIDTH(32), .DATA_WIDTH(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .cancel_if(cancel_if),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; cancel_if = 0; ls_req = 0; ls_we = 0; bus_ready = 0; bus_rvalid = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_wmask = 0; bus_rdata = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs(); if_req = 1; ls_req = 1;
        nxt();
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got if=%b ls=%b want 0 0", if_gnt, ls_gnt); end
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wmask !== 4'h0) begin errors++; $display("FAIL rst_bus: got req=%b we=%b addr=%h wdata=%h mask=%h want all 0", bus_req, bus_we, bus_addr, bus_wdata, bus_wmask); end
        checks++; if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got if=%b ls=%b want 0 0", if_rvalid, ls_rvalid); end
        nxt();
        rst_n = 1; clear_inputs();
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin errors++; $display("FAIL rst_idle_gnt: got if=%b ls=%b want 0 0", if_gnt, ls_gnt); end
        nxt();
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h100; bus_ready = 1;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL sf_gnt: got %b want 1", if_gnt); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL sf_req_n: got %b want 0", bus_req); end
        nxt(); if_req = 0;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin errors++; $display("FAIL sf_issue: got req=%b addr=%h want 1 100", bus_req, bus_addr); end
        checks++; if (bus_we !== 1'b0 || bus_wmask !== 4'h0) begin errors++; $display("FAIL sf_rd: got we=%b mask=%h want 0 0", bus_we, bus_wmask); end
        nxt(); bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sf_rdata: got v=%b d=%h want 1 deadbeef", if_rvalid, if_rdata); end
        checks++; if (ls_rvalid !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL sf_ls_quiet: got lsv=%b req=%b want 0 0", ls_rvalid, bus_req); end
        nxt(); bus_rvalid = 0; bus_ready = 0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL sf_pulse: got %b want 0", if_rvalid); end
        nxt();
    endtask

    task automatic test_contention();
        if_req = 1; if_addr = 32'h300;
        ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'hCAFEF00D; ls_wmask = 4'b0011;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL ct_prio: got ls=%b if=%b want 1 0", ls_gnt, if_gnt); end
        nxt(); ls_req = 0; bus_ready = 1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wmask !== 4'b0011) begin errors++; $display("FAIL ct_store: got req=%b we=%b mask=%h want 1 1 3", bus_req, bus_we, bus_wmask); end
        checks++; if (bus_addr !== 32'h200 || bus_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ct_payload: got addr=%h wdata=%h want 200 cafef00d", bus_addr, bus_wdata); end
        nxt(); bus_rvalid = 1; bus_rdata = 32'h0;
        @(negedge clk);
        checks++; if (ls_rvalid !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL ct_ack: got lsv=%b ifg=%b want 1 0", ls_rvalid, if_gnt); end
        nxt(); bus_rvalid = 0;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1 || ls_rvalid !== 1'b0) begin errors++; $display("FAIL ct_if_gnt: got ifg=%b lsv=%b want 1 0", if_gnt, ls_rvalid); end
        nxt(); if_req = 0;
        @(negedge clk);
        checks++; if (bus_addr !== 32'h300 || bus_we !== 1'b0 || bus_wmask !== 4'h0) begin errors++; $display("FAIL ct_if_issue: got addr=%h we=%b mask=%h want 300 0 0", bus_addr, bus_we, bus_wmask); end
        nxt(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h12345678;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h12345678) begin errors++; $display("FAIL ct_if_data: got v=%b d=%h want 1 12345678", if_rvalid, if_rdata); end
        nxt(); bus_rvalid = 0;
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 32'h400; bus_ready = 0;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL fl_gnt: got %b want 1", if_gnt); end
        nxt(); if_req = 0; cancel_if = 1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fl_req1: got %b want 1", bus_req); end
        nxt(); cancel_if = 0; ls_req = 1; ls_we = 0; ls_addr = 32'h500; ls_wmask = 4'hF;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || ls_gnt !== 1'b0) begin errors++; $display("FAIL fl_hold: got req=%b lsg=%b want 1 0", bus_req, ls_gnt); end
        nxt();
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fl_req3: got %b want 1", bus_req); end
        nxt(); bus_ready = 1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || ls_gnt !== 1'b0) begin errors++; $display("FAIL fl_accept: got req=%b lsg=%b want 1 0", bus_req, ls_gnt); end
        nxt(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h00000BAD;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b0 || bus_req !== 1'b0 || ls_gnt !== 1'b0) begin errors++; $display("FAIL fl_drop: got ifv=%b req=%b lsg=%b want 0 0 0", if_rvalid, bus_req, ls_gnt); end
        nxt(); bus_rvalid = 0;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL fl_ls_gnt: got %b want 1", ls_gnt); end
        nxt(); ls_req = 0; bus_ready = 1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h500 || bus_we !== 1'b0) begin errors++; $display("FAIL fl_ls_issue: got req=%b addr=%h we=%b want 1 500 0", bus_req, bus_addr, bus_we); end
        nxt(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h000055AA;
        @(negedge clk);
        checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h000055AA || if_rvalid !== 1'b0) begin errors++; $display("FAIL fl_ls_data: got v=%b d=%h ifv=%b want 1 55aa 0", ls_rvalid, ls_rdata, if_rvalid); end
        nxt(); bus_rvalid = 0;
    endtask

    task automatic test_cancel_same_cycle();
        if_req = 1; cancel_if = 1; if_addr = 32'hB00;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL cs_masked: got %b want 0", if_gnt); end
        nxt(); cancel_if = 0;
        @(negedge clk);
        checks++; if (bus_req !== 1'b0 || if_gnt !== 1'b1) begin errors++; $display("FAIL cs_regnt: got req=%b ifg=%b want 0 1", bus_req, if_gnt); end
        nxt(); if_req = 0; bus_ready = 1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'hB00) begin errors++; $display("FAIL cs_issue: got req=%b addr=%h want 1 b00", bus_req, bus_addr); end
        nxt(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'hFEEDFACE;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hFEEDFACE) begin errors++; $display("FAIL cs_data: got v=%b d=%h want 1 feedface", if_rvalid, if_rdata); end
        nxt(); bus_rvalid = 0;
    endtask

    task automatic test_backpressure();
        ls_req = 1; ls_we = 1; ls_addr = 32'h600; ls_wdata = 32'hA5A5A5A5; ls_wmask = 4'b1100; bus_ready = 0;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt: got %b want 1", ls_gnt); end
        nxt(); ls_addr = 32'h700; ls_wdata = 32'h0; ls_wmask = 4'hF; if_req = 1; if_addr = 32'h800;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus_addr !== 32'h600 || bus_wdata !== 32'hA5A5A5A5 || bus_wmask !== 4'b1100) begin errors++; $display("FAIL bp_stable[%0d]: got addr=%h wdata=%h mask=%h want 600 a5a5a5a5 c", i, bus_addr, bus_wdata, bus_wmask); end
            checks++; if (bus_req !== 1'b1 || ls_gnt !== 1'b0 || if_gnt !== 1'b0) begin errors++; $display("FAIL bp_nogrant[%0d]: got req=%b lsg=%b ifg=%b want 1 0 0", i, bus_req, ls_gnt, if_gnt); end
            nxt();
        end
        bus_ready = 1; ls_req = 0; if_req = 0;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL bp_req: got %b want 1", bus_req); end
        nxt(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h0;
        @(negedge clk);
        checks++; if (ls_rvalid !== 1'b1) begin errors++; $display("FAIL bp_ack: got %b want 1", ls_rvalid); end
        nxt(); bus_rvalid = 0;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b0 || if_gnt !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL bp_idle: got lsg=%b ifg=%b req=%b want 0 0 0", ls_gnt, if_gnt, bus_req); end
        nxt();
    endtask

    task automatic test_back_to_back();
        ls_req = 1; ls_we = 0; ls_addr = 32'h900; bus_ready = 1;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL bb_gnt1: got %b want 1", ls_gnt); end
        nxt(); ls_req = 0;
        nxt(); bus_rvalid = 1; bus_rdata = 32'h11; ls_req = 1; ls_addr = 32'hA00;
        @(negedge clk);
        checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h11 || ls_gnt !== 1'b0) begin errors++; $display("FAIL bb_ack1: got v=%b d=%h g=%b want 1 11 0", ls_rvalid, ls_rdata, ls_gnt); end
        nxt(); bus_rvalid = 0;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL bb_gnt2: got %b want 1", ls_gnt); end
        nxt(); ls_req = 0;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'hA00) begin errors++; $display("FAIL bb_issue2: got req=%b addr=%h want 1 a00", bus_req, bus_addr); end
        nxt(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h22;
        @(negedge clk);
        checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h22) begin errors++; $display("FAIL bb_ack2: got v=%b d=%h want 1 22", ls_rvalid, ls_rdata); end
        nxt(); bus_rvalid = 0;
    endtask

    task automatic test_reset_mid_wait();
        ls_req = 1; ls_we = 0; ls_addr = 32'h800;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL rw_gnt: got %b want 1", ls_gnt); end
        nxt(); ls_req = 0; bus_ready = 1;
        nxt(); bus_ready = 0; rst_n = 0;
        nxt(); rst_n = 1; bus_rvalid = 1; bus_rdata = 32'h777;
        @(negedge clk);
        checks++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0 || ls_gnt !== 1'b0) begin errors++; $display("FAIL rw_stale: got lsv=%b ifv=%b lsg=%b want 0 0 0", ls_rvalid, if_rvalid, ls_gnt); end
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0) begin errors++; $display("FAIL rw_bus: got req=%b we=%b addr=%h want 0 0 0", bus_req, bus_we, bus_addr); end
        nxt(); bus_rvalid = 0;
    endtask

    task automatic test_priority();
        logic exp_if;
        if_req = 1; if_addr = 32'hD00; ls_req = 1; ls_we = 0; ls_addr = 32'hC00;
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_if = (i == 4);
`else
            exp_if = 1'b0;
`endif
            @(negedge clk);
            checks++; if (if_gnt !== exp_if || ls_gnt !== !exp_if) begin errors++; $display("FAIL pr_grant[%0d]: got ifg=%b lsg=%b want %b %b", i, if_gnt, ls_gnt, exp_if, !exp_if); end
            nxt(); nxt(); nxt();
        end
        clear_inputs();
        nxt();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_flush();
        test_cancel_same_cycle();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
